// File: rtl/difftest_commit_serializer.sv
// difftest_commit_serializer
// Gathers up to SLOTS retired instructions per cycle, compacts them into an
// in-order FIFO and replays them one per cycle on a single commit channel.
// Also owns the cycle/instruction counters and the end-of-simulation trap
// sequence (RUN -> DRAIN -> REPORT -> HALT), with state held in `state`.
//
// Handshakes: the input group (all valid slots plus in_trap) is taken on a
// rising edge where in_ready is high; in_ready depends only on registered
// state, and the producer holds the group while it is low. A commit leaves on
// a rising edge where out_valid & out_ready; the head fields stay stable
// while out_valid is high and out_ready is low.
module difftest_commit_serializer #(
    parameter int SLOTS = 2,
    parameter int DEPTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [SLOTS-1:0]      in_valid,
    input  logic [64*SLOTS-1:0]   in_pc,
    input  logic [32*SLOTS-1:0]   in_instr,
    input  logic                  in_trap,
    input  logic [2:0]            in_trap_code,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [63:0]           out_pc,
    output logic [31:0]           out_instr,
    output logic [7:0]            out_index,
    output logic                  trap_valid,
    output logic [2:0]            trap_code,
    output logic [63:0]           trap_cycle_cnt,
    output logic [63:0]           trap_instr_cnt,
    output logic                  halted
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {RUN, DRAIN, REPORT, HALT} state_t;

    state_t          state;
    state_t          state_next;

    logic [63:0]     mem_pc    [DEPTH];
    logic [31:0]     mem_instr [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic [CW-1:0]   push_cnt;
    logic [CW-1:0]   push_amt;
    logic [CW-1:0]   pop_amt;
    logic [AW-1:0]   slot_addr [SLOTS];
    logic            pop;

    logic [63:0]     cycle_cnt;
    logic [63:0]     instr_cnt;
    logic [2:0]      code_q;
    logic [63:0]     trap_cycle_q;
    logic [63:0]     trap_instr_q;

    // Slot compaction: each valid slot lands at wr_ptr plus the number of valid slots below it
    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < SLOTS; i++) begin
            slot_addr[i] = wr_ptr + AW'(push_cnt);
            if (in_valid[i]) begin
                push_cnt = push_cnt + CW'(1);
            end
        end
        pop        = out_valid & out_ready;
        push_amt   = in_ready ? push_cnt : '0;
        pop_amt    = {{(CW-1){1'b0}}, pop};
        count_next = count + push_amt - pop_amt;
    end

    // FIFO storage; contents need no reset because count gates visibility
    always_ff @(posedge clock) begin
        if (in_ready) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (in_valid[i]) begin
                    mem_pc[slot_addr[i]]    <= in_pc[64*i +: 64];
                    mem_instr[slot_addr[i]] <= in_instr[32*i +: 32];
                end
            end
        end
    end

    // Pointers, fill count, counters and trap bookkeeping
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            cycle_cnt    <= '0;
            instr_cnt    <= '0;
            code_q       <= '0;
            trap_cycle_q <= '0;
            trap_instr_q <= '0;
        end else begin
            count <= count_next;
            if (in_ready) begin
                wr_ptr <= wr_ptr + AW'(push_cnt);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                instr_cnt <= instr_cnt + 64'd1;
            end
            if (state != HALT) begin
                cycle_cnt <= cycle_cnt + 64'd1;
            end
            if (in_ready && in_trap) begin
                code_q <= in_trap_code;
            end
            // Hold the reported values so they remain readable once halted
            if (state == REPORT) begin
                trap_cycle_q <= cycle_cnt;
                trap_instr_q <= instr_cnt;
            end
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: drain ends on the cycle the FIFO will be empty, so the report follows the last pop
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (in_ready && in_trap) state_next = DRAIN;
            DRAIN:   if (count_next == '0) state_next = REPORT;
            REPORT:  state_next = HALT;
            default: state_next = HALT;
        endcase
    end

    // Outputs: acceptance from registered count only, head fields zeroed when nothing is valid
    always_comb begin
        in_ready       = (state == RUN) && ((CW'(DEPTH) - count) >= CW'(SLOTS));
        out_valid      = ((state == RUN) || (state == DRAIN)) && (count != '0);
        out_pc         = out_valid ? mem_pc[rd_ptr] : '0;
        out_instr      = out_valid ? mem_instr[rd_ptr] : '0;
        out_index      = instr_cnt[7:0];
        trap_valid     = (state == REPORT);
        trap_code      = code_q;
        trap_cycle_cnt = (state == REPORT) ? cycle_cnt : trap_cycle_q;
        trap_instr_cnt = (state == REPORT) ? instr_cnt : trap_instr_q;
        halted         = (state == HALT);
    end

endmodule
